// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } seg_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Enough BCD nibbles to hold any DATA_LEN-bit unsigned value.
    function automatic int unsigned bcd_digits(input int unsigned data_len);
        return (data_len * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per cycle,
// result held stable while done is high.
module seg_bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned BCD_DIGITS = bcd_digits(32)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_LEN-1:0]     data,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] result
);

    localparam int unsigned CNT_W = $clog2(DATA_LEN + 1);
    localparam int unsigned BCD_W = BCD_DIGITS * 4;

    seg_state_t          state, state_next;
    logic [DATA_LEN-1:0] shift_q;
    logic [BCD_W-1:0]    scratch, adjusted;
    logic [CNT_W-1:0]    bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Add-3 correction and the shift happen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            scratch <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shift_q <= data;
                    scratch <= '0;
                    bit_cnt <= CNT_W'(DATA_LEN);
                end
                SHIFT: begin
                    {scratch, shift_q} <= {adjusted[BCD_W-2:0], shift_q, 1'b0};
                    bit_cnt            <= bit_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ready  = (state == IDLE);
    assign busy   = (state == SHIFT);
    assign done   = (state == COMMIT);
    assign result = scratch;

endmodule

// File: rtl/seg_display_scheduler.sv
// Display-path front end: handshake, BCD conversion, atomic digit commit, scan mux.
// Optional macro SEG_SATURATE_EN: overflowing values display as all nines.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_BITS = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_LEN-1:0]   in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [3:0]            bcd_out
);

    localparam int unsigned BCD_DIGITS = bcd_digits(DATA_LEN);
    localparam int unsigned SEL_W      = $clog2(NUM_DIGITS);
    localparam int unsigned DISP_W     = NUM_DIGITS * 4;

    logic                    conv_done;
    logic [BCD_DIGITS*4-1:0] conv_result;
    logic                    ovf_next;
    logic [DISP_W-1:0]       commit_digits;
    logic [DISP_W-1:0]       display;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [SEL_W-1:0]        sel, nib_idx;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [3:0]              bcd_next;

    seg_bin2bcd_seq #(
        .DATA_LEN   (DATA_LEN),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (in_valid & in_ready),
        .data   (in_data),
        .ready  (in_ready),
        .busy   (busy),
        .done   (conv_done),
        .result (conv_result)
    );

    always_comb begin
        ovf_next = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            ovf_next = ovf_next | (|conv_result[i*4 +: 4]);
        end
`ifdef SEG_SATURATE_EN
        commit_digits = ovf_next ? {NUM_DIGITS{BCD_NINE}} : conv_result[DISP_W-1:0];
`else
        commit_digits = conv_result[DISP_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display  <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            display  <= commit_digits;
            overflow <= ovf_next;
        end
    end

    // Digit 0 is the most significant, stored in the top nibble; both it and
    // its anode bit sit at position NUM_DIGITS-1-sel, i.e. the inverted select.
    assign sel     = refresh_cnt[REFRESH_BITS-1 -: SEL_W];
    assign nib_idx = ~sel;

    always_comb begin
        anode_next          = '1;
        anode_next[nib_idx] = 1'b0;
        bcd_next            = display[{nib_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            anode       <= {1'b0, {(NUM_DIGITS-1){1'b1}}};
            bcd_out     <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            anode       <= anode_next;
            bcd_out     <= bcd_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler with a cycle-level reference model.
module tb_seg_display_scheduler;

    localparam int unsigned DL = 32;
    localparam int unsigned ND = 4;
    localparam int unsigned RB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DL-1:0] in_data = '0;
    logic          in_ready, busy, overflow;
    logic [ND-1:0] anode;
    logic [3:0]    bcd_out;

    int vectors = 0;
    int miscompares = 0;

    seg_display_scheduler #(
        .DATA_LEN     (DL),
        .NUM_DIGITS   (ND),
        .REFRESH_BITS (RB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .overflow (overflow),
        .anode    (anode),
        .bcd_out  (bcd_out)
    );

    always #5 clk = ~clk;

    // Reference model: the value shown is a plain integer 0..9999; timing is
    // counted in edges since the accepting edge (commit lands 33 edges later).
    int       cnt_m = 0;
    int       disp_m = 0;
    bit       ovf_m = 1'b0;
    bit       active = 1'b0;
    int       k = 0;
    longint   val_m = 0;
    bit       ready_pre;
    logic [3:0] exp_anode = 4'b0111;
    logic [3:0] exp_bcd = 4'd0;
    bit       exp_ready = 1'b1;
    bit       exp_busy = 1'b0;

    function automatic int digit_of(input int v, input int pos);
        int p = 1;
        for (int j = pos; j < 3; j++) p = p * 10;
        return (v / p) % 10;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cnt_m = 0; disp_m = 0; ovf_m = 1'b0; active = 1'b0; k = 0;
            exp_anode = 4'b0111; exp_bcd = 4'd0;
        end else begin
            exp_anode = 4'b1111 ^ (4'b1000 >> (cnt_m / 4));
            exp_bcd   = 4'(digit_of(disp_m, cnt_m / 4));
            cnt_m     = (cnt_m + 1) % 16;
            ready_pre = !active;
            if (active) begin
                k++;
                if (k == 33) begin
                    ovf_m  = (val_m > 9999);
                    disp_m = int'(val_m % 10000);
`ifdef SEG_SATURATE_EN
                    if (ovf_m) disp_m = 9999;
`endif
                    active = 1'b0;
                end
            end
            if (ready_pre && in_valid) begin
                active = 1'b1;
                k      = 0;
                val_m  = longint'(in_data);
            end
        end
        exp_ready = !active;
        exp_busy  = active && (k <= 31);
    end

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {1'b1, 1'b0, 1'b0, 4'b0111, 4'd0}) begin
                miscompares++;
                $display("FAIL reset: got rdy/bsy/ovf/an/bcd=%b want %b",
                         {in_ready, busy, overflow, anode, bcd_out}, {1'b1, 1'b0, 1'b0, 4'b0111, 4'd0});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd}) begin
                miscompares++;
                $display("FAIL reset_scan cyc %0d: got %b want %b", i,
                         {in_ready, busy, overflow, anode, bcd_out}, {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd});
            end
        end
    endtask

    // One-cycle request, then noise on in_valid during the conversion (must be ignored).
    task automatic test_convert(input logic [DL-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd}) begin
                miscompares++;
                $display("FAIL convert %0d cyc %0d: got %b want %b", v, i,
                         {in_ready, busy, overflow, anode, bcd_out}, {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd});
            end
            in_valid = (i < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = $urandom;
        end
    endtask

    task automatic test_back_to_back;
        in_data  = 42;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 9999;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd}) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i,
                         {in_ready, busy, overflow, anode, bcd_out}, {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd});
            end
            if (i == 40) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_abort;
        in_data  = 5678;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd}) begin
                miscompares++;
                $display("FAIL reset_abort cyc %0d: got %b want %b", i,
                         {in_ready, busy, overflow, anode, bcd_out}, {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd});
            end
            in_valid = 1'b0;
            reset    = (i == 9);
        end
        test_convert($urandom_range(0, 9999));
    endtask

    task automatic test_atomic;
        int prev_cls = 0;
        int cls;
        int switches = 0;
        test_convert(1111);
        in_data  = 2222;
        in_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, busy, overflow, anode, bcd_out} !== {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd}) begin
                miscompares++;
                $display("FAIL atomic cyc %0d: got %b want %b", i,
                         {in_ready, busy, overflow, anode, bcd_out}, {exp_ready, exp_busy, ovf_m, exp_anode, exp_bcd});
            end
            in_valid = 1'b0;
            cls = (bcd_out == 4'd1) ? 1 : (bcd_out == 4'd2) ? 2 : 0;
            if (cls != prev_cls && prev_cls != 0) switches++;
            prev_cls = cls;
        end
        vectors++;
        if (switches !== 1) begin
            miscompares++;
            $display("FAIL atomic_switches: got %0d want 1", switches);
        end
    endtask

    task automatic test_random;
        logic [DL-1:0] v;
        for (int n = 0; n < 9; n++) begin
            case (n % 3)
                0:       v = $urandom;
                1:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(9990, 10010);
            endcase
            test_convert(v);
        end
    endtask

    initial begin
        test_reset;
        test_convert(1234);
        test_convert(32'hFFFF_FFFF);
        test_convert(0);
        test_convert(9999);
        test_convert(10000);
        test_back_to_back;
        test_reset_abort;
        test_atomic;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Sequencing front-end for the 4-digit seven-segment display path.
- Accepts a binary result through a valid/ready handshake and converts it to BCD over multiple cycles (sequential double-dabble, no divide/modulo hardware).
- Commits the digits atomically to a display register.
- Time-multiplexes the digits onto the anode-select and 4-bit BCD outputs that feed the cathode decoder.

Parameters:
- DATA_LEN, 32: width of the binary input.
- NUM_DIGITS, 4: displayed digits. Must be a power of two, 2..8.
- REFRESH_BITS, 19: refresh counter width. The top log2(NUM_DIGITS) bits select the digit.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_LEN  unsigned binary value to display.
- in_ready  out  1  block can accept a value.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value needed more than NUM_DIGITS digits.
- anode  out  NUM_DIGITS  active-low one-cold digit enable. MSB enables digit 0 (most significant).
- bcd_out  out  4  BCD digit for the currently enabled anode.

Behaviour:
- Localparam BCD_DIGITS = (DATA_LEN*3)/10 + 1. This is 10 for DATA_LEN = 32. The scratch register is BCD_DIGITS*4 bits wide.
- Reset (synchronous, highest priority):
  - state = IDLE, refresh counter = 0.
  - Display register = all zeros, overflow = 0, busy = 0, in_ready = 1.
  - anode = 0111 for NUM_DIGITS = 4, bcd_out = 0.
  - Reset during SHIFT aborts the conversion; the display shows 0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready: load shift register = in_data, clear scratch, set bit counter = DATA_LEN, go to SHIFT.
- SHIFT:
  - in_ready = 0, busy = 1.
  - Each cycle: every scratch nibble >= 5 gets +3, then {scratch, shift} shifts left by 1. Both happen in the same cycle.
  - Bit counter decrements. Move to COMMIT when the cycle that processes the last bit completes, i.e. exactly DATA_LEN SHIFT cycles.
  - in_valid is ignored while in SHIFT (no queuing).
- COMMIT (1 cycle):
  - Copy the low NUM_DIGITS nibbles to the display register.
  - overflow = OR of all higher scratch nibbles.
  - busy = 0. Go to IDLE; in_ready = 1 on the next cycle.
- Latency: handshake at cycle 0 → display register updated at the end of cycle DATA_LEN+1 (33 for the default). Maximum throughput is one value per DATA_LEN+2 cycles.
- The display register changes only in COMMIT, so the scan never shows a mix of old and new digits.
- Scan:
  - Refresh counter is free-running and wraps modulo 2^REFRESH_BITS. It is unaffected by the FSM.
  - sel = counter[REFRESH_BITS-1 -: log2(NUM_DIGITS)].
  - anode has bit (NUM_DIGITS-1-sel) low and all others high. bcd_out = digit sel, with digit 0 the most significant.
  - anode and bcd_out are registered from sel and change together, one cycle after the sel transition.
- No leading-zero blanking: 0 displays as 0000.
- Overflow without the optional feature: the display shows the value modulo 10^NUM_DIGITS and the overflow flag is raised.

Optional Feature:
- Macro: SEG_SATURATE_EN.
- Defined: on overflow, COMMIT loads all digits with 9 (9999 for 4 digits). overflow still asserts.
- Undefined: modulo display as described in Behaviour.

Decomposition:
- Shared package seg_pkg:
  - FSM state enum (seg_state_t: IDLE, SHIFT, COMMIT).
  - Constant function bcd_digits(DATA_LEN).
  - Constant BCD_NINE = 4'd9.
- Sub-module seg_bin2bcd_seq:
  - Owns the shift/scratch registers, bit counter and FSM.
  - Exposes start/ready/done plus a BCD_DIGITS*4 result.
  - Top level keeps the display register, overflow/saturation logic and scan.

Test Plan (REFRESH_BITS = 4 for simulation speed):
1. Reset held 2 cycles → anode = 0111, bcd_out = 0, in_ready = 1, busy = 0, overflow = 0. Release; full scan shows 0,0,0,0.
2. in_data = 1234 with in_valid for 1 cycle → in_ready low for 33 cycles. After commit, the scan yields 1,2,3,4 on anodes 0111, 1011, 1101, 1110; overflow = 0.
3. in_data = 0xFFFFFFFF (4294967295) → digits 7,2,9,5 and overflow = 1. With SEG_SATURATE_EN: 9,9,9,9 and overflow = 1.
4. Hold in_valid high with values 42 then 9999 → 42 accepted; 9999 accepted only on the first cycle in_ready returns high. Display shows 0042, then 9999 with overflow = 0.
5. Assert reset 10 cycles into the conversion of 5678 → immediately IDLE; display 0000, overflow = 0. The next accepted value converts correctly.
6. Commit 1111, then convert 2222 while monitoring the scan → no scan period shows a mix of 1s and 2s except across the single COMMIT boundary.
